// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the adder-sharing sequencer: slice/operand widths,
// requester ids and the FSM state encoding.
package adder_share_ctrl_pkg;

  localparam int SLICE_W = 16;
  localparam int OP_W    = 2 * SLICE_W;

  localparam logic REQ_PC  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder16_ci.sv
// 16-bit ripple-carry adder slice with carry-in and carry-out, chained from
// full-adder cells. A 32-bit add is done as two passes through this slice.
module adder16_ci
  import adder_share_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[SLICE_W];

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the shared ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one 16-bit adder slice between the PC unit
// (req0) and the ALU (req1); wide adds take a second pass through the slice.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_a,
  input  logic [OP_W-1:0] req0_b,
  input  logic            req0_wide,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_a,
  input  logic [OP_W-1:0] req1_b,
  input  logic            req1_wide,
  output logic            req1_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [OP_W-1:0] rsp_sum,
  output logic            rsp_carry,
  output logic            rsp_ovf
);

  state_t state, state_next;

  logic            last_grant;
  logic            grant_valid;
  logic            grant_id;
  logic [OP_W-1:0] op_a, op_b;
  logic            op_wide;
  logic            op_id;

  logic [SLICE_W-1:0] sum_lo, sum_hi;
  logic               c16, c32;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cin, slice_cout;

  // Grants only happen in IDLE; on a tie the requester not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_PC;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = REQ_PC;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = REQ_ALU;
      end
    end
    req0_ready = grant_valid && (grant_id == REQ_PC);
    req1_ready = grant_valid && (grant_id == REQ_ALU);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = LO;
      LO:      state_next = op_wide ? HI : DONE;
      HI:      state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The high pass reuses the slice with the registered low-half carry.
  always_comb begin
    slice_a   = op_a[SLICE_W-1:0];
    slice_b   = op_b[SLICE_W-1:0];
    slice_cin = 1'b0;
    if (state == HI) begin
      slice_a   = op_a[OP_W-1:SLICE_W];
      slice_b   = op_b[OP_W-1:SLICE_W];
      slice_cin = c16;
    end
  end

  adder16_ci u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (slice_cin),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_ALU;
      op_a       <= '0;
      op_b       <= '0;
      op_wide    <= 1'b0;
      op_id      <= REQ_PC;
      sum_lo     <= '0;
      sum_hi     <= '0;
      c16        <= 1'b0;
      c32        <= 1'b0;
    end else begin
      if (grant_valid) begin
        last_grant <= grant_id;
        op_id      <= grant_id;
        op_a       <= (grant_id == REQ_PC) ? req0_a    : req1_a;
        op_b       <= (grant_id == REQ_PC) ? req0_b    : req1_b;
        op_wide    <= (grant_id == REQ_PC) ? req0_wide : req1_wide;
      end
      if (state == LO) begin
        sum_lo <= slice_sum;
        c16    <= slice_cout;
      end
      if (state == HI) begin
        sum_hi <= slice_sum;
        c32    <= slice_cout;
      end
    end
  end

  // Response fields are driven only in DONE so they read zero at all other times.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_id    = REQ_PC;
    rsp_sum   = '0;
    rsp_carry = 1'b0;
    rsp_ovf   = 1'b0;
    if (state == DONE) begin
      rsp_valid = 1'b1;
      rsp_id    = op_id;
      if (op_wide) begin
        rsp_sum   = {sum_hi, sum_lo};
        rsp_carry = c32;
        rsp_ovf   = signed_ovf(op_a[OP_W-1], op_b[OP_W-1], sum_hi[SLICE_W-1]);
      end else begin
        rsp_sum   = {{SLICE_W{1'b0}}, sum_lo};
        rsp_carry = c16;
        rsp_ovf   = signed_ovf(op_a[SLICE_W-1], op_b[SLICE_W-1], sum_lo[SLICE_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: directed requests push expected
// responses, a negedge monitor pops and compares on each response handshake.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_wide, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_wide, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf;
  logic [31:0] rsp_sum;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_exp;
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk = ~clk;

  adder_share_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_wide (req0_wide),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_wide (req1_wide),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
  endtask

  function automatic rsp_t mk(input logic id, input logic [31:0] sum, input logic carry, input logic ovf);
    rsp_t r;
    r.id = id; r.sum = sum; r.carry = carry; r.ovf = ovf;
    return r;
  endfunction

  task automatic set_req(input int port, input logic valid, input logic [31:0] a,
                         input logic [31:0] b, input logic wide);
    if (port == 0) begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_wide = wide;
    end else begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_wide = wide;
    end
  endtask

  // Waits for acceptance, scrambles operands afterwards, then times the response.
  task automatic applyStimulus(input string name, input int port, input logic [31:0] a,
                               input logic [31:0] b, input logic wide, input rsp_t exp);
    int   n;
    int   lat;
    logic accepted;
    set_req(port, 1'b1, a, b, wide);
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) accepted = 1'b1;
      n++;
    end
    checkOutput({name, "_accept"}, 32'(accepted), 32'd1);
    if (accepted) exp_q.push_back(exp);
    @(posedge clk); #1;
    set_req(port, 1'b0, $urandom, $urandom, ~wide);
    if (accepted) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 20);
      checkOutput({name, "_latency"}, 32'(lat), wide ? 32'd3 : 32'd2);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) begin
        checkOutput("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
        checkOutput("ready_needs_valid",
                    32'((req0_ready && !req0_valid) || (req1_ready && !req1_valid)), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("rsp_id",    32'(rsp_id),    32'(mon_exp.id));
          checkOutput("rsp_sum",   rsp_sum,        mon_exp.sum);
          checkOutput("rsp_carry", 32'(rsp_carry), 32'(mon_exp.carry));
          checkOutput("rsp_ovf",   32'(rsp_ovf),   32'(mon_exp.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   grants;
    int   n;
    int   lat;
    logic accepted;

    reset = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h1, 32'h2, 1'b0);
    set_req(1, 1'b1, 32'h3, 32'h4, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_sum",   rsp_sum,        32'd0);
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("reset_rsp_carry", 32'(rsp_carry), 32'd0);
    checkOutput("reset_rsp_ovf",   32'(rsp_ovf),   32'd0);
    checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed adds");
    applyStimulus("narrow_carry", 0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, mk(1'b0, 32'h0000_0000, 1'b1, 1'b0));
    applyStimulus("wide_carry",   1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, mk(1'b1, 32'h0001_0000, 1'b0, 1'b0));
    applyStimulus("wide_ovf",     1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, mk(1'b1, 32'h8000_0000, 1'b0, 1'b1));
    applyStimulus("wide_allones", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0));
    applyStimulus("narrow_ovf",   1, 32'h1234_7FFF, 32'hABCD_0001, 1'b0, mk(1'b1, 32'h0000_8000, 1'b0, 1'b1));

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus("bp_narrow", 0, 32'h0000_1234, 32'h0000_4321, 1'b0, mk(1'b0, 32'h0000_5555, 1'b0, 1'b0));
    set_req(1, 1'b1, 32'h0001_8000, 32'h0002_8000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_sum",   rsp_sum,        32'h0000_5555);
      checkOutput("bp_hold_id",    32'(rsp_id),    32'd0);
      checkOutput("bp_no_ready",   32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_no_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp_accept_after", 32'(req1_ready), 32'd1);
    if (req1_ready) exp_q.push_back(mk(1'b1, 32'h0004_0000, 1'b0, 1'b0));
    @(posedge clk); #1;
    set_req(1, 1'b0, $urandom, $urandom, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    checkOutput("bp_pending_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    $display("[TB] reset during high pass");
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      @(negedge clk);
      if (req0_ready) accepted = 1'b1;
      n++;
    end
    checkOutput("rstmid_accept", 32'(accepted), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_hi_no_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstmid_rsp_sum",   rsp_sum,        32'd0);
    checkOutput("rstmid_rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("rstmid_rsp_carry", 32'(rsp_carry), 32'd0);
    checkOutput("rstmid_rsp_ovf",   32'(rsp_ovf),   32'd0);
    checkOutput("rstmid_ready0",    32'(req0_ready), 32'd0);
    checkOutput("rstmid_ready1",    32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] round-robin with both requesters held valid");
    set_req(0, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_req(1, 1'b1, 32'h1000_0000, 32'h2000_0000, 1'b1);
    grants = 0;
    n = 0;
    while (grants < 4 && n < 100) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        checkOutput("rr_grant_order", 32'(req1_ready), 32'(grants % 2));
        if (req0_ready) exp_q.push_back(mk(1'b0, 32'h0000_0030, 1'b0, 1'b0));
        else            exp_q.push_back(mk(1'b1, 32'h3000_0000, 1'b0, 1'b0));
        grants++;
      end
      n++;
    end
    checkOutput("rr_grant_count", 32'(grants), 32'd4);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
